// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one single-port SRAM (CSN/WEN/BE, one-cycle read latency) between the
// instruction-fetch port (read only) and the load/store port of the core.
// Data requests win by default; read data returns to the owning port one cycle
// after its grant. STALL_CNT counts cycles in which any request was denied.
//
// Optional feature: define ARB_FAIRNESS_EN to let a fetch request that has been
// denied MAX_WAIT consecutive cycles win the next contended cycle. Without the
// macro, data priority is strict and fetch can be starved.

module riscv_mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int AWIDTH   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    // fetch port
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [31:0]       I_RDATA,
    // load/store port
    input  logic              D_REQ,
    input  logic              D_WEN,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [3:0]        D_BE,
    input  logic [31:0]       D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    // SRAM side
    output logic              M_CSN,
    output logic              M_WEN,
    output logic [AWIDTH-1:0] M_ADDR,
    output logic [3:0]        M_BE,
    output logic [31:0]       M_DI,
    input  logic [31:0]       M_DOUT,
    // contention statistics
    output logic [31:0]       STALL_CNT
);

    // Handshake: a port raises REQ with its address/data and holds them stable
    // until it sees GNT high. Every cycle with REQ and GNT both high consumes
    // exactly one SRAM access; the port may drop or change REQ afterwards. A
    // read returns RVALID/RDATA exactly one cycle after its GNT.

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    // Who owns the SRAM read data returning next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t            owner_q;
    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic [31:0]       stall_q;
    logic [WAIT_W-1:0] wait_q;

    logic              gnt_i;
    logic              gnt_d;
    logic              fair_due;
    logic              any_denied;

    // Address bits [1:0] select a byte inside the word and never reach the SRAM.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{I_ADDR[1:0], D_ADDR[1:0]};

`ifdef ARB_FAIRNESS_EN
    assign fair_due = (wait_q == WAIT_W'(MAX_WAIT));
`else
    assign fair_due = 1'b0;
`endif

    // Pick at most one winner per cycle; nothing is granted while in reset.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (RSTn) begin
            if (I_REQ && D_REQ) begin
                if (fair_due) begin
                    gnt_i = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_i = I_REQ;
                gnt_d = D_REQ;
            end
        end
    end

    assign I_GNT      = gnt_i;
    assign D_GNT      = gnt_d;
    assign any_denied = (I_REQ && !gnt_i) || (D_REQ && !gnt_d);

    // Drive the SRAM from the winner in the grant cycle; idle drives all zero.
    always_comb begin
        M_CSN  = 1'b1;
        M_WEN  = 1'b1;
        M_ADDR = '0;
        M_BE   = 4'b0000;
        M_DI   = 32'h0;
        if (gnt_d) begin
            M_CSN  = 1'b0;
            M_WEN  = D_WEN;
            M_ADDR = D_ADDR[AWIDTH+1:2];
            M_BE   = D_WEN ? 4'b0000 : D_BE;
            M_DI   = D_WDATA;
        end else if (gnt_i) begin
            M_CSN  = 1'b0;
            M_WEN  = 1'b1;
            M_ADDR = I_ADDR[AWIDTH+1:2];
            M_BE   = 4'b0000;
            M_DI   = D_WDATA;
        end
    end

    // Owner state and registered RVALIDs: record which port's read is in flight.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            owner_q    <= OWN_NONE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else if (gnt_d && D_WEN) begin
            owner_q    <= OWN_D;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b1;
        end else if (gnt_i) begin
            owner_q    <= OWN_I;
            i_rvalid_q <= 1'b1;
            d_rvalid_q <= 1'b0;
        end else begin
            owner_q    <= OWN_NONE;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end
    end

    assign I_RVALID = i_rvalid_q;
    assign D_RVALID = d_rvalid_q;
    assign I_RDATA  = (owner_q == OWN_I) ? M_DOUT : 32'h0;
    assign D_RDATA  = (owner_q == OWN_D) ? M_DOUT : 32'h0;

    // Saturating count of cycles in which some request was left waiting.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_q <= 32'h0;
        end else if (any_denied && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign STALL_CNT = stall_q;

    // Consecutive fetch denials, saturating at MAX_WAIT; cleared by a fetch
    // grant or by the fetch port going idle.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wait_q <= '0;
        end else if (I_REQ && !gnt_i) begin
            if (wait_q != WAIT_W'(MAX_WAIT)) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
        end else begin
            wait_q <= '0;
        end
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port SRAM (CSN/WEN/BE, one-cycle read latency) between the core's instruction-fetch port and its load/store port.
- Lets the CPU run from a unified I/D memory image instead of two separate SP_SRAM instances.
- Grants at most one access per cycle and returns read data to the owning requester one cycle after grant.
- Counts cycles lost to contention so the bench can report arbitration cost next to NUM_INST.

Parameters:
- ADDR_W, 12, requester byte-address width.
- AWIDTH, 10, SRAM word-address width; M_ADDR = ADDR[AWIDTH+1:2].
- MAX_WAIT, 4, consecutive instruction-port denials before the fairness override (only with ARB_FAIRNESS_EN).

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, synchronous, active-low
- I_REQ  in  1  fetch request (read only)
- I_ADDR  in  ADDR_W  fetch byte address
- I_GNT  out  1  fetch accepted this cycle
- I_RVALID  out  1  I_RDATA valid
- I_RDATA  out  32  fetch data
- D_REQ  in  1  data request
- D_WEN  in  1  0 = write, 1 = read (SRAM polarity)
- D_ADDR  in  ADDR_W  data byte address
- D_BE  in  4  byte enables for writes
- D_WDATA  in  32  write data
- D_GNT  out  1  data accepted this cycle
- D_RVALID  out  1  D_RDATA valid
- D_RDATA  out  32  load data
- M_CSN  out  1  SRAM chip select, active-low
- M_WEN  out  1  SRAM write enable, active-low
- M_ADDR  out  AWIDTH  SRAM word address
- M_BE  out  4  SRAM byte enables
- M_DI  out  32  SRAM write data
- M_DOUT  in  32  SRAM read data, valid the cycle after a read
- STALL_CNT  out  32  saturating count of cycles in which a request was denied

Behaviour:
- Reset (RSTn = 0 at posedge): I_RVALID = 0, D_RVALID = 0, owner register = NONE, STALL_CNT = 0, fairness counter = 0.
  - While RSTn = 0, I_GNT = D_GNT = 0, M_CSN = 1 and M_WEN = 1; all requests are ignored.
- Grant logic is combinational in the request cycle:
  - D_REQ wins over I_REQ by default.
  - A single request is granted immediately.
  - No request: M_CSN = 1, M_WEN = 1, M_BE = 0, M_ADDR = 0, M_DI = 0.
- Granted access drives the SRAM in the same cycle:
  - M_CSN = 0.
  - M_WEN = D_WEN for data, 1 for fetch.
  - M_ADDR from the winner's address bits [AWIDTH+1:2]; address bits [1:0] are ignored.
  - M_BE = D_BE for data writes, 4'b0000 for reads.
  - M_DI = D_WDATA.
- Handshake:
  - A requester holds REQ and its address/data stable until GNT.
  - GNT high for one cycle consumes exactly one access.
  - REQ may be dropped or changed after the GNT cycle.
- Read return:
  - The owner register records I, D or NONE at each posedge; NONE covers writes and idle cycles.
  - Next cycle the owner's RVALID = 1 and its RDATA = M_DOUT; the non-owner's RDATA = 0.
  - Read latency is exactly 1 cycle after GNT.
- Back-to-back grants are allowed every cycle; RVALID of access N and GNT of access N+1 may coincide.
- Writes produce no RVALID.
- STALL_CNT increments by 1 in any cycle where I_REQ or D_REQ is high without its GNT; it saturates at 32'hFFFFFFFF.
- Simultaneous requests: the loser sees GNT = 0 and stays pending; no request is ever dropped.
- Reset mid-read: the pending RVALID is cancelled (0 the cycle after reset); the read is lost and the requester reissues it.

Optional Feature:
- ARB_FAIRNESS_EN defined:
  - A saturating counter tracks consecutive cycles with I_REQ = 1 and I_GNT = 0.
  - When it reaches MAX_WAIT, the next contended cycle grants I instead of D.
  - The counter clears on any I grant or when I_REQ = 0.
- ARB_FAIRNESS_EN undefined: strict data priority; the fetch port can be starved indefinitely by continuous D_REQ.

Test Plan:
- Fetch-only read: preload word 5 = 32'h00A00093; I_REQ = 1, I_ADDR = 12'h014 -> I_GNT same cycle, M_ADDR = 5, I_RVALID next cycle with I_RDATA = 32'h00A00093, STALL_CNT = 0.
- Data write then read: D_WEN = 0, D_ADDR = 12'h0EF0, D_BE = 4'b0011, D_WDATA = 32'hDEADBEEF over old 32'h11223344; then read the same address -> D_RDATA = 32'h1122BEEF, D_RVALID exactly 1 cycle after the read grant, no D_RVALID for the write.
- Contention: I_REQ and D_REQ both high for one cycle -> D granted first, I granted the next cycle; RVALIDs on consecutive cycles to the correct ports; STALL_CNT = 1.
- Starvation (ARB_FAIRNESS_EN, MAX_WAIT = 4): D_REQ held high, I_REQ high -> I_GNT on the 5th cycle, STALL_CNT = 4 at that point. Without the macro, I_GNT stays 0 for 100 cycles.
- Reset mid-read: grant a D read, assert RSTn = 0 on the next posedge -> D_RVALID = 0, M_CSN = 1, STALL_CNT = 0.
- Idle: no requests for 10 cycles -> M_CSN = 1, M_WEN = 1, both RVALIDs 0, STALL_CNT unchanged.
